// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the ALU control sequencer:
//   - state_t     : fetch/execute state encoding (4-bit state register)
//   - OP_*        : ALU opcode encodings carried in ir[31:27]
//   - *_LSB       : IR field positions (op, Ra, Rb, Rc)
//   - is_unary / is_muldiv / is_valid : opcode class helpers
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T5U  = 4'd7,
        T6   = 4'd8,
        HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_SHR = 5'b00110;
    localparam logic [4:0] OP_SHL = 5'b00111;
    localparam logic [4:0] OP_ROR = 5'b01000;
    localparam logic [4:0] OP_ROL = 5'b01001;
    localparam logic [4:0] OP_MUL = 5'b01010;
    localparam logic [4:0] OP_DIV = 5'b01011;
    localparam logic [4:0] OP_NEG = 5'b01100;
    localparam logic [4:0] OP_NOT = 5'b01101;

    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Defined opcodes form one contiguous range ADD..NOT.
    function automatic logic is_valid(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_control_sequencer_if
// Bundle between the control sequencer and the Datapath.
//   Datapath -> sequencer : run, ir[31:0], mem_ready
//   sequencer -> Datapath : bus strobes (PCout, Zlowout, Zhighout, MDRout),
//                           load strobes (MARin, Zin, PCin, MDRin, IRin, Yin,
//                           HIin, LOin), IncPC, Read, Rout/Rin one-hot,
//                           opcode, instr_done, halted
// master = sequencer side, slave = Datapath side.
// ---------------------------------------------------------------------------
interface alu_control_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
);
    logic                run;
    logic [31:0]         ir;
    logic                mem_ready;

    logic                PCout, Zlowout, Zhighout, MDRout;
    logic                MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic                IncPC, Read;
    logic [NUM_REGS-1:0] Rout;
    logic [NUM_REGS-1:0] Rin;
    logic [OPW-1:0]      opcode;
    logic                instr_done;
    logic                halted;

    modport master (
        input  run, ir, mem_ready,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        output IncPC, Read, Rout, Rin, opcode, instr_done, halted
    );

    modport slave (
        output run, ir, mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        input  IncPC, Read, Rout, Rin, opcode, instr_done, halted
    );
endinterface

// File: rtl/alu_control_sequencer_reg_select_decoder.sv
// ---------------------------------------------------------------------------
// reg_select_decoder
// Converts a 4-bit register index plus enable into a NUM_REGS-wide one-hot
// select. Used for both the Rout (bus drive) and Rin (load) buses.
//   idx    in  4         register number
//   en     in  1         0 forces the output to all zeros
//   onehot out NUM_REGS  one-hot select
// ---------------------------------------------------------------------------
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        // Indices beyond the register file select nothing.
        if (en && (32'(idx) < NUM_REGS))
            onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/alu_control_sequencer.sv
// ---------------------------------------------------------------------------
// alu_control_sequencer
// Control unit FSM for the Datapath: fetch (T0-T2) followed by execute
// (T3-T6) of R-format ALU instructions, then back to fetch.
//   clock  in  1   system clock, rising edge
//   clear  in  1   asynchronous active-high reset to IDLE
//   step   in  1   only with SEQ_SINGLE_STEP_EN defined
//   bus    alu_control_sequencer_if.master (run, ir, mem_ready in;
//          all Datapath control strobes out)
// Optional feature SEQ_SINGLE_STEP_EN: IDLE leaves only on a step pulse,
// run is ignored, and every instruction returns to IDLE after instr_done.
// Outputs are Moore-decoded from the state register and the IR fields.
// ---------------------------------------------------------------------------
module alu_control_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic clock,
    input  logic clear,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic step,
`endif
    alu_control_sequencer_if.master bus
);
    state_t     state;
    logic       pc_first;   // high only during the first T1 cycle
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       start;
    state_t     done_next;

    logic       rout_en, rin_en, op_en;
    logic [3:0] rout_idx;

    assign op = bus.ir[OP_LSB +: 5];
    assign ra = bus.ir[RA_LSB +: 4];
    assign rb = bus.ir[RB_LSB +: 4];
    assign rc = bus.ir[RC_LSB +: 4];

`ifdef SEQ_SINGLE_STEP_EN
    assign start     = step;
    assign done_next = IDLE;
`else
    assign start     = bus.run;
    assign done_next = bus.run ? T0 : IDLE;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            pc_first <= 1'b0;
        end else begin
            pc_first <= (state == T0);
            case (state)
                IDLE: if (start) state <= T0;
                T0:   state <= T1;
                T1:   if (bus.mem_ready) state <= T2;
                T2:   state <= T3;
                T3: begin
                    if (!is_valid(op))    state <= HALT;
                    else if (is_unary(op)) state <= T5U;
                    else                   state <= T4;
                end
                T4:   state <= T5;
                T5:   state <= is_muldiv(op) ? T6 : done_next;
                T5U:  state <= done_next;
                T6:   state <= done_next;
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PCout      = 1'b0;
        bus.Zlowout    = 1'b0;
        bus.Zhighout   = 1'b0;
        bus.MDRout     = 1'b0;
        bus.MARin      = 1'b0;
        bus.Zin        = 1'b0;
        bus.PCin       = 1'b0;
        bus.MDRin      = 1'b0;
        bus.IRin       = 1'b0;
        bus.Yin        = 1'b0;
        bus.HIin       = 1'b0;
        bus.LOin       = 1'b0;
        bus.IncPC      = 1'b0;
        bus.Read       = 1'b0;
        bus.instr_done = 1'b0;
        bus.halted     = 1'b0;
        rout_en        = 1'b0;
        rout_idx       = rb;
        rin_en         = 1'b0;
        op_en          = 1'b0;
        case (state)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = pc_first;   // PC loads once even if memory stalls
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                if (is_valid(op)) begin
                    rout_en = 1'b1;
                    if (is_unary(op)) begin
                        op_en   = 1'b1;
                        bus.Zin = 1'b1;
                    end else begin
                        bus.Yin = 1'b1;
                    end
                end
            end
            T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                op_en    = 1'b1;
                bus.Zin  = 1'b1;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv(op)) begin
                    bus.LOin = 1'b1;
                end else begin
                    rin_en         = 1'b1;
                    bus.instr_done = 1'b1;
                end
            end
            T5U: begin
                bus.Zlowout    = 1'b1;
                rin_en         = 1'b1;
                bus.instr_done = 1'b1;
            end
            T6: begin
                bus.Zhighout   = 1'b1;
                bus.HIin       = 1'b1;
                bus.instr_done = 1'b1;
            end
            HALT: bus.halted = 1'b1;
            default: ;
        endcase
        bus.opcode = op_en ? OPW'(op) : '0;
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (bus.Rout)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .idx    (ra),
        .en     (rin_en),
        .onehot (bus.Rin)
    );

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Control unit FSM that drives the Datapath's control inputs: PCout, Zlowout, MARin, Read, IRin, Yin, per-register Rin/Rout, the ALU opcode, and so on.
- Sequences instruction fetch (T0-T2) and execution (T3-T6) for R-format ALU instructions, then loops back to fetch.
- Sits beside Datapath and replaces the hand-written per-test state sequencing.
- Takes IR contents and a memory-ready handshake; emits one-cycle-wide control strobes.

Parameters:
- NUM_REGS, 16, number of general registers (width of Rin/Rout one-hot buses).
- OPW, 5, width of the instruction and ALU opcode fields.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  asynchronous, active-high reset.
- run  in  1  level; when 0, the FSM holds in IDLE before the next fetch.
- ir  in  32  current IR contents (Datapath IR output).
- mem_ready  in  1  memory has valid data on Mdatain this cycle.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load strobes.
- IncPC, Read  out  1 each  PC increment, memory read.
- Rout  out  NUM_REGS  one-hot general-register bus drive.
- Rin  out  NUM_REGS  one-hot general-register load.
- opcode  out  OPW  ALU operation; 0 when not in an ALU state.
- instr_done  out  1  one-cycle pulse in the final execute state.
- halted  out  1  high while in HALT.

Behaviour:
- IR fields: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- State register is 4 bits. All outputs are Moore-decoded from the state register and the IR fields, valid for the full cycle and sampled by Datapath at the next posedge.
- Reset: clear=1 forces IDLE asynchronously; every output is 0, including opcode.
- IDLE: all outputs 0. run=1 -> T0, else stay.
- T0: PCout, MARin, IncPC, Zin -> T1.
- T1: Zlowout, PCin, Read, MDRin.
  - PCin is asserted only on the first T1 cycle (use a 1-bit flag); Read and MDRin are held every cycle.
  - Exit to T2 on the cycle mem_ready=1, else stay in T1.
- T2: MDRout, IRin -> T3.
- T3 by op:
  - Binary ops: Rout[Rb], Yin -> T4.
  - Unary ops (NEG, NOT): Rout[Rb], opcode=op, Zin -> T5U.
  - Undefined op: -> HALT.
- T4: Rout[Rc], opcode=op, Zin -> T5.
- T5:
  - MUL/DIV: Zlowout, LOin -> T6.
  - Otherwise: Zlowout, Rin[Ra], instr_done -> T0 if run, else IDLE.
- T5U: Zlowout, Rin[Ra], instr_done -> T0/IDLE, same rule as T5.
- T6: Zhighout, HIin, instr_done -> T0/IDLE.
- HALT: halted=1, all other outputs 0; exits only via clear.
- Opcode encodings: ADD 00010, SUB 00011, AND 00100, OR 00101, SHR 00110, SHL 00111, ROR 01000, ROL 01001, MUL 01010, DIV 01011, NEG 01100, NOT 01101. Everything else is undefined.
- Rout and Rin are never both asserted for the same register in one cycle. At most one bus-drive output is active per cycle.
- run deasserted mid-instruction has no effect until the instruction completes.
- clear mid-instruction returns to IDLE immediately with no partial register write.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - IDLE advances to T0 only on a step=1 cycle; run is ignored.
  - After instr_done the FSM always returns to IDLE.
- Undefined: no step port; run-based behaviour as above.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, T0, T1, T2, T3, T4, T5, T5U, T6, HALT);
  - the opcode localparams;
  - IR field bit positions;
  - is_unary/is_muldiv/is_valid functions.
- Natural sub-module reg_select_decoder: 4-bit index plus enable -> NUM_REGS one-hot, used for Rout and Rin.

Test Plan:
- clear=1 at 0 ns, released at 25 ns; run=0 -> all outputs 0, state IDLE for 5 cycles, halted=0.
- run=1, mem_ready=1, ir=SUB R1,R2,R3 (op 00011, Ra=1, Rb=2, Rc=3):
  - T0-T5 sequence completes in 6 cycles;
  - T3: Rout=0x0004, Yin=1;
  - T4: Rout=0x0008, opcode=3, Zin=1;
  - T5: Rin=0x0002, instr_done pulse.
- Fetch with mem_ready=0 for 3 cycles:
  - FSM stays in T1 for 4 cycles total;
  - PCin high only in the first of those cycles;
  - Read/MDRin high in all of them;
  - advances to T2 after mem_ready=1.
- MUL R4,R5,R6 (op 01010):
  - T5: Zlowout, LOin, Rin=0;
  - T6: Zhighout, HIin, instr_done;
  - next cycle is T0.
- NOT R7,R8 (op 01101):
  - T3: Rout=0x0100, opcode=0x0D, Zin;
  - T5U: Rin=0x0080;
  - 5 cycles total.
- ir op=11111 -> HALT after T3, halted=1 persists; clear asserted mid-instruction -> all outputs 0 within the same cycle, returns to IDLE.
